detector_vel_4: RTL and testbench

Four-speed pulse-rate decoder: the receiving end of the motor time base. It measures the half-period of the incoming `vel` toggle and recovers which of the four speed codes produced it, with a lock indication, an out-of-window error and a stall (no-toggle) flag. It sits on the motor-control side, downstream of the time base or of an external pin carrying that signal, and feeds speed status to the controller.

---
 rtl/motor_pkg.sv | 9 +
 rtl/sync_edge.sv | 13 +
 rtl/detector_vel_4.sv | 83 ++++++++
 tb/tb_detector_vel_4.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared types, speed-interval helper and default clock frequency for motor control
package motor_pkg;
  localparam int F_DEFAULT = 50000000;
  typedef enum logic [1:0] {IDLE, ARM, CAND, LOCK} state_t;
  typedef logic [1:0] speed_t;
  function automatic int n_k(input int f, input int k);
    return (f >> k) + 1;
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer plus delay flop giving a one-cycle pulse on either input edge
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3} <= '0;
    else     {s1, s2, s3} <= {d, s1, s2};
  assign pulse = s2 ^ s3;
endmodule

// File: rtl/detector_vel_4.sv
// detector_vel_4: recovers the speed code from the vel half-period, with lock, error and stall status
module detector_vel_4
  import motor_pkg::*;
#(
  parameter int F   = F_DEFAULT,
  parameter int TOL = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vel_in,
  output logic [1:0] sel_out,
  output logic       valid,
  output logic       err,
  output logic       stall
);
  localparam int W    = $clog2(F + TOL + 3);
  localparam int TOUT = F + TOL + 2;
  logic         ep, hit, tout;
  logic [W-1:0] cnt;
  logic [3:0]   match;
  int           e;
  speed_t       code, cand;
  state_t       state;
  sync_edge u_sync (.clk(clk), .rst(rst), .d(vel_in), .pulse(ep));
  // e is the interval that would be measured if an edge arrived this cycle
  assign e = int'(cnt) + 1;
  for (genvar k = 0; k < 4; k++) begin : g_win
    assign match[k] = (e >= n_k(F, k) - TOL) && (e <= n_k(F, k) + TOL);
  end
  assign hit  = |match;
  assign code = match[3] ? 2'd3 : match[2] ? 2'd2 : match[1] ? 2'd1 : 2'd0;
  assign tout = (state != IDLE) && (e == TOUT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= '0;
      cnt     <= '0;
      sel_out <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      stall   <= 1'b0;
    end else begin
      err <= 1'b0;
      cnt <= (state == IDLE || ep || tout) ? '0 : cnt + 1'b1;
      if (ep) begin
        case (state)
          IDLE: begin
            state <= ARM;
            stall <= 1'b0;
          end
          ARM:
            if (hit) begin
              state <= CAND;
              cand  <= code;
            end else err <= 1'b1;
          CAND:
            if (!hit) begin
              err   <= 1'b1;
              state <= ARM;
            end else if (code == cand) begin
              state   <= LOCK;
              sel_out <= code;
              valid   <= 1'b1;
            end else cand <= code;
          default:
            if (!hit) begin
              err   <= 1'b1;
              state <= ARM;
              valid <= 1'b0;
            end else if (code != cand) begin
              cand  <= code;
              state <= CAND;
              valid <= 1'b0;
            end
        endcase
      end else if (tout) begin
        state <= IDLE;
        valid <= 1'b0;
        stall <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_detector_vel_4.sv
// tb_detector_vel_4: scoreboard bench driving vel toggles at chosen intervals and checking decoded status
module tb_detector_vel_4;
  logic       clk = 1'b0, rst = 1'b1, vel_in = 1'b0;
  logic [1:0] sel_out;
  logic       valid, err, stall;
  detector_vel_4 #(.F(80), .TOL(2)) dut (
    .clk(clk), .rst(rst), .vel_in(vel_in),
    .sel_out(sel_out), .valid(valid), .err(err), .stall(stall)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [1:0] sel; logic valid; logic err; logic stall;} exp_t;
  exp_t       q[$];
  int         n_cmp = 0, n_bad = 0;
  int         spent = 0;
  int         m_st = 0, m_cand = 0;
  logic [1:0] m_sel = 2'd0;
  logic       m_valid = 1'b0, m_stall = 1'b0;
  int         lo[4] = '{79, 39, 19, 9};
  int         hi[4] = '{83, 43, 23, 13};

  function automatic int win(input int p);
    for (int k = 0; k < 4; k++)
      if (p >= lo[k] && p <= hi[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cand = 0; m_sel = 2'd0; m_valid = 1'b0; m_stall = 1'b0;
  endtask

  // toggle vel_in p cycles after the previous toggle and check 3 clk later
  task automatic step(input int p, input string tag);
    exp_t x, got;
    int k;
    repeat ((p > spent) ? p - spent : 0) @(posedge clk);
    #1 vel_in = ~vel_in;
    k = win(p);
    x = '0;
    case (m_st)
      0: begin m_st = 1; m_stall = 1'b0; end
      1: if (k >= 0) begin m_st = 2; m_cand = k; end else x.err = 1'b1;
      2: if (k < 0) begin x.err = 1'b1; m_st = 1; end
         else if (k == m_cand) begin m_st = 3; m_sel = 2'(k); m_valid = 1'b1; end
         else m_cand = k;
      default: if (k < 0) begin x.err = 1'b1; m_st = 1; m_valid = 1'b0; end
               else if (k != m_cand) begin m_st = 2; m_cand = k; m_valid = 1'b0; end
    endcase
    x.sel = m_sel; x.valid = m_valid; x.stall = m_stall;
    q.push_back(x);
    repeat (3) @(posedge clk);
    #1;
    x = q.pop_front();
    got = {sel_out, valid, err, stall};
    n_cmp++;
    if (got !== x) begin
      n_bad++;
      $display("FAIL %s: sel/valid/err/stall got %b want %b", tag, got, x);
    end
    spent = 3;
    if (x.err) begin
      @(posedge clk);
      #1;
      spent = 4;
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_err_width: err got %b want 0", tag, err);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({sel_out, valid, err, stall} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset: got %b want 00000", {sel_out, valid, err, stall});
    end
    rst = 1'b0;
    model_reset();
    spent = 0;
  endtask

  task automatic test_lock41();
    step(5, "l41_first");
    step(41, "l41_cand");
    step(41, "l41_lock");
    step(41, "l41_hold");
  endtask

  task automatic test_switch();
    step(11, "sw_first");
    step(11, "sw_lock");
  endtask

  task automatic test_err();
    step(81, "e_cand0");
    step(81, "e_lock0");
    step(30, "e_bad");
    step(81, "e_recand");
    step(81, "e_relock");
  endtask

  task automatic test_bounds();
    step(79, "b_79");
    step(83, "b_83");
    step(78, "b_78");
    step(81, "b_cand");
    step(84, "b_84");
  endtask

  task automatic test_stall();
    step(21, "st_cand");
    step(21, "st_lock");
    repeat (83) @(posedge clk);
    #1;
    n_cmp++;
    if ({valid, stall} !== 2'b10) begin
      n_bad++;
      $display("FAIL stall_early: valid/stall got %b want 10", {valid, stall});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({sel_out, valid, err, stall} !== 5'b10001) begin
      n_bad++;
      $display("FAIL stall_set: got %b want 10001", {sel_out, valid, err, stall});
    end
    m_st = 0; m_valid = 1'b0; m_stall = 1'b1;
    repeat (10) @(posedge clk);
    spent = 0;
    step(5, "st_clear");
  endtask

  task automatic test_reset_mid();
    step(21, "rm_cand");
    step(21, "rm_lock");
    rst = 1'b1;
    vel_in = 1'b0;
    #1;
    n_cmp++;
    if ({sel_out, valid, err, stall} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got %b want 00000", {sel_out, valid, err, stall});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    spent = 0;
    step(5, "rm_first");
    step(21, "rm_cand2");
    step(21, "rm_relock");
  endtask

  initial begin
    test_reset();
    test_lock41();
    test_switch();
    test_err();
    test_bounds();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
